memo_unpacker: RTL and testbench
================================

// Module: memo_unpacker
// PURPOSE
//  Consumer side of the memo_struct_t signal path. Accepts a stream of packed memo_struct_t
//  words (parts_hi[3:0], signed parts_lo[1:0]) through a valid/ready handshake and buffers them
//  in an unpacked struct array. On pop it presents each word as separate fields, keeps a signed
//  running sum of parts_lo, and keeps a packed [1:0][3:0] history of the last two parts_hi values.
//  Sits directly downstream of the memo producer.
// PARAMETERS
//  DEPTH  4  FIFO entries; must be a power of two and >= 2
//  ACC_W  8  accumulator width in bits; must be >= 3
// PORTS
//  clk        in   1              single clock, rising edge
//  rst_n      in   1              asynchronous active-low reset
//  clear      in   1              synchronous flush of FIFO, accumulator and history
//  in_valid   in   1              producer has a word
//  in_ready   out  1              space available
//  in_data    in   memo_struct_t  packed word: [5:2]=parts_hi, [1:0]=parts_lo (signed)
//  out_valid  out  1              head entry valid
//  out_ready  in   1              consumer accepts head
//  out_hi     out  4              head parts_hi
//  out_lo     out  signed 8       head parts_lo, sign-extended to 8 bits
//  acc        out  signed ACC_W   running sum of sign-extended popped parts_lo
//  hist       out  [1:0][3:0]     hist[0]=last popped parts_hi, hist[1]=the one before
//  count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (rst_n=0, async): storage pointers=0, count=0, acc=0, hist='0. in_ready=1, out_valid=0.
//  - Push: in_valid && in_ready. Pop: out_valid && out_ready. in_ready=(count!=DEPTH); out_valid=(count!=0).
//  - No bypass: a word pushed into an empty FIFO gives out_valid=1 on the next cycle (1-cycle latency).
//  - out_hi/out_lo are combinational from the head entry; when out_valid=0 their values are don't-care.
//  - Simultaneous push and pop: both take effect; count unchanged. Pointers wrap modulo DEPTH.
//  - Full: in_ready=0, so no push happens even if a pop occurs in the same cycle.
//  - On pop: acc <= acc + sext(parts_lo), two's-complement wrap at ACC_W with no saturation;
//    hist[1] <= hist[0]; hist[0] <= parts_hi.
//  - clear=1: next cycle count=0, pointers=0, acc=0, hist=0. clear overrides any push/pop in the same cycle.
//    The handshake signals keep their usual combinational meaning during clear; a word offered while
//    clear=1 is dropped.
//  - Reset asserted mid-stream discards all contents immediately; no partial output is held.
//  - parts_lo encodings: 2'b10 -> -2, 2'b11 -> -1, 2'b00 -> 0, 2'b01 -> +1.
// STRUCTURE
//  - memo_pkg: memo_struct_t typedef, MEMO_HI_W=4, MEMO_LO_W=2 constants. Shared with the producer.
//  - Sub-module memo_fifo: parameterised by DEPTH and element type, with an unpacked storage
//    array, wrapping read/write pointers and occupancy count.
//  - memo_unpacker holds the field split, sign extension, accumulator and history registers.
// TESTING
//  1. Reset with in_valid=0 -> in_ready=1, out_valid=0, acc=0, hist=0, count=0.
//  2. Push {hi=4'hA, lo=2'b11} with out_ready=0 -> next cycle out_valid=1, out_hi=A, out_lo=-1, count=1.
//     Then pop -> acc=-1, hist[0]=A.
//  3. Push 5 words with out_ready=0 (DEPTH=4) -> in_ready=0 after the 4th; the 5th is not accepted; count=4.
//  4. Full FIFO, in_valid=1, out_ready=1 for one cycle -> one pop and no push, count=3.
//     Next cycle push and pop both occur, count stays 3.
//  5. Pop 130 words with lo=2'b01 (ACC_W=8) -> acc wraps to -126 (8'h82).
//     hist holds the last two parts_hi values in order.
//  6. clear asserted together with push and pop at count=2 -> next cycle count=0, acc=0, hist=0, out_valid=0.
//     Repeat with async rst_n pulse mid-burst -> same state.

Source files
------------

// File: rtl/memo_pkg.sv
// Shared memo word definitions used by the memo producer and the unpacker.
// No logic, no latency.
// No flow control.
package memo_pkg;

    localparam int MEMO_HI_W = 4;
    localparam int MEMO_LO_W = 2;

    // Packed layout on the wire: [5:2] = parts_hi, [1:0] = parts_lo (two's complement)
    typedef struct packed {
        logic        [MEMO_HI_W-1:0] parts_hi;
        logic signed [MEMO_LO_W-1:0] parts_lo;
    } memo_struct_t;

endpackage

// File: rtl/memo_fifo.sv
// Generic synchronous FIFO: unpacked storage, wrapping pointers, occupancy count.
// Latency: a written entry is visible at rd_data on the next cycle (no bypass).
// Backpressure: push is ignored while full, pop is ignored while empty; clear wins over both.
module memo_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wr_data,
    output T                         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    T                r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;

    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == (PW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_do_push = push && !full && !clear;
    assign w_do_pop  = pop && !empty && !clear;

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/memo_unpacker.sv
// Buffers memo words and presents each popped word as separate fields with running sum and history.
// Latency: 1 cycle from push to out_valid (no bypass); fields are combinational from the head entry.
// Backpressure: in_ready drops when DEPTH entries are held; a pop never frees space for a same-cycle push.
module memo_unpacker
    import memo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ACC_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  memo_struct_t               in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [MEMO_HI_W-1:0]       out_hi,
    output logic signed [7:0]          out_lo,
    output logic signed [ACC_W-1:0]    acc,
    output logic [1:0][MEMO_HI_W-1:0]  hist,
    output logic [$clog2(DEPTH):0]     count
);

    memo_struct_t              w_head;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic signed [ACC_W-1:0]   w_lo_ext;

    logic signed [ACC_W-1:0]       r_acc;
    logic [1:0][MEMO_HI_W-1:0]     r_hist;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_hi    = w_head.parts_hi;
    assign out_lo    = {{(8-MEMO_LO_W){w_head.parts_lo[MEMO_LO_W-1]}}, w_head.parts_lo};
    assign w_lo_ext  = {{(ACC_W-MEMO_LO_W){w_head.parts_lo[MEMO_LO_W-1]}}, w_head.parts_lo};
    assign acc       = r_acc;
    assign hist      = r_hist;

    memo_fifo #(
        .DEPTH (DEPTH),
        .T     (memo_struct_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data (in_data),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (count)
    );

    // Running sum of popped parts_lo (wraps at ACC_W) and two-deep parts_hi history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_hist <= '0;
        end else if (clear) begin
            r_acc  <= '0;
            r_hist <= '0;
        end else if (w_pop) begin
            r_acc     <= r_acc + w_lo_ext;
            r_hist[1] <= r_hist[0];
            r_hist[0] <= w_head.parts_hi;
        end
    end

endmodule

// File: tb/tb_memo_unpacker.sv
// Self-checking bench for memo_unpacker: directed vector table, wrap/reset sequences, random vs model.
// Inputs are driven 1 time unit after the rising edge; outputs are checked there too.
// Flow control is exercised by randomising in_valid, out_ready and clear.
module tb_memo_unpacker;
    import memo_pkg::*;

    localparam int DEPTH = 4;
    localparam int ACC_W = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  clear;
    logic                  in_valid;
    logic                  in_ready;
    memo_struct_t          in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            out_hi;
    logic signed [7:0]     out_lo;
    logic signed [ACC_W-1:0] acc;
    logic [1:0][3:0]       hist;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural reference state
    memo_struct_t mq[$];
    int           macc;
    logic [3:0]   mh0;
    logic [3:0]   mh1;

    memo_unpacker #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hi    (out_hi),
        .out_lo    (out_lo),
        .acc       (acc),
        .hist      (hist),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit         clr;
        bit         iv;
        logic [5:0] d;
        bit         ordy;
        bit         e_ir;
        bit         e_ov;
        int         e_cnt;
        logic [7:0] e_acc;
        logic [3:0] e_h0;
        logic [3:0] e_h1;
        logic [3:0] e_hi;
        logic [7:0] e_lo;
    } vec_t;

    vec_t tbl [11];

    function automatic int lo_val(input logic [1:0] lo);
        case (lo)
            2'b10:   return -2;
            2'b11:   return -1;
            2'b01:   return 1;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        macc = 0;
        mh0  = '0;
        mh1  = '0;
    endtask

    // Apply one cycle of inputs and advance the reference model by the same cycle
    task automatic step(input bit c, input bit iv, input logic [5:0] d, input bit ordy);
        int           sz;
        bit           do_push;
        bit           do_pop;
        memo_struct_t w;
        clear     = c;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        sz        = mq.size();
        do_push   = iv && (sz < DEPTH);
        do_pop    = ordy && (sz > 0);
        @(posedge clk);
        #1;
        if (c) begin
            model_reset();
        end else begin
            if (do_pop) begin
                w    = mq.pop_front();
                macc = macc + lo_val(w.parts_lo);
                mh1  = mh0;
                mh0  = w.parts_hi;
            end
            if (do_push) begin
                mq.push_back(memo_struct_t'(d));
            end
        end
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, " count"},     32'(count),         32'(sz));
        chk({tag, " in_ready"},  32'(in_ready),      32'(sz != DEPTH));
        chk({tag, " out_valid"}, 32'(out_valid),     32'(sz != 0));
        chk({tag, " acc"},       {24'd0, acc},       {24'd0, 8'(macc)});
        chk({tag, " hist0"},     32'(hist[0]),       32'(mh0));
        chk({tag, " hist1"},     32'(hist[1]),       32'(mh1));
        if (sz != 0) begin
            chk({tag, " out_hi"}, 32'(out_hi),       32'(mq[0].parts_hi));
            chk({tag, " out_lo"}, {24'd0, out_lo},   {24'd0, 8'(lo_val(mq[0].parts_lo))});
        end
    endtask

    initial begin
        //            clr iv  d          ordy ir ov cnt acc    h0    h1    hi    lo
        tbl[0]  = '{0, 1, 6'b1010_11, 0, 1, 1, 1, 8'h00, 4'h0, 4'h0, 4'hA, 8'hFF};
        tbl[1]  = '{0, 0, 6'b0000_00, 1, 1, 0, 0, 8'hFF, 4'hA, 4'h0, 4'h0, 8'h00};
        tbl[2]  = '{0, 1, 6'b0001_01, 0, 1, 1, 1, 8'hFF, 4'hA, 4'h0, 4'h1, 8'h01};
        tbl[3]  = '{0, 1, 6'b0010_10, 0, 1, 1, 2, 8'hFF, 4'hA, 4'h0, 4'h1, 8'h01};
        tbl[4]  = '{0, 1, 6'b0011_00, 0, 1, 1, 3, 8'hFF, 4'hA, 4'h0, 4'h1, 8'h01};
        tbl[5]  = '{0, 1, 6'b0100_01, 0, 0, 1, 4, 8'hFF, 4'hA, 4'h0, 4'h1, 8'h01};
        tbl[6]  = '{0, 1, 6'b0101_11, 0, 0, 1, 4, 8'hFF, 4'hA, 4'h0, 4'h1, 8'h01};
        tbl[7]  = '{0, 1, 6'b0110_01, 1, 1, 1, 3, 8'h00, 4'h1, 4'hA, 4'h2, 8'hFE};
        tbl[8]  = '{0, 1, 6'b0110_01, 1, 1, 1, 3, 8'hFE, 4'h2, 4'h1, 4'h3, 8'h00};
        tbl[9]  = '{0, 0, 6'b0000_00, 1, 1, 1, 2, 8'hFE, 4'h3, 4'h2, 4'h4, 8'h01};
        tbl[10] = '{1, 1, 6'b0111_01, 1, 1, 0, 0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00};

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset state
        #3;
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset acc",       {24'd0, acc},   32'd0);
        chk("reset hist",      32'(hist),      32'd0);
        chk("reset count",     32'(count),     32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].clr, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("row%0d in_ready", i),  32'(in_ready),  32'(tbl[i].e_ir));
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("row%0d count", i),     32'(count),     32'(tbl[i].e_cnt));
            chk($sformatf("row%0d acc", i),       {24'd0, acc},   {24'd0, tbl[i].e_acc});
            chk($sformatf("row%0d hist0", i),     32'(hist[0]),   32'(tbl[i].e_h0));
            chk($sformatf("row%0d hist1", i),     32'(hist[1]),   32'(tbl[i].e_h1));
            if (tbl[i].e_ov) begin
                chk($sformatf("row%0d out_hi", i), 32'(out_hi),       32'(tbl[i].e_hi));
                chk($sformatf("row%0d out_lo", i), {24'd0, out_lo},   {24'd0, tbl[i].e_lo});
            end
        end

        // Accumulator wrap: 130 pops of +1 from zero lands on -126
        for (int i = 0; i < 130; i++) begin
            logic [31:0] iv32;
            iv32 = 32'(i);
            step(1'b0, 1'b1, {iv32[3:0], 2'b01}, 1'b0);
            step(1'b0, 1'b0, 6'd0, 1'b1);
        end
        chk("wrap acc",   {24'd0, acc}, 32'h82);
        chk("wrap hist0", 32'(hist[0]), 32'h1);
        chk("wrap hist1", 32'(hist[1]), 32'h0);
        check_model("wrap");

        // Async reset mid-burst with two entries held
        step(1'b0, 1'b1, 6'b1100_10, 1'b0);
        step(1'b0, 1'b1, 6'b1101_11, 1'b0);
        chk("preburst count", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst count",     32'(count),     32'd0);
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst in_ready",  32'(in_ready),  32'd1);
        chk("arst acc",       {24'd0, acc},   32'd0);
        chk("arst hist",      32'(hist),      32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_model("post_arst");

        // Randomised traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0),
                 6'($urandom),
                 ($urandom_range(0, 1) == 1));
            check_model($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
